// File: rtl/ref_fetch_pkg.sv
// Shared constants for the reference-sequence port-A read sequencer.
// State encodings and word/byte geometry used by the control and the FIFO.
package ref_fetch_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_SHIFT     = 2;

endpackage

// File: rtl/ref_fetch_fifo.sv
// Synchronous first-word-fall-through return buffer for fetched words.
// Flush empties it in one cycle; push and pop may coincide at full or empty.
module ref_fetch_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    push,
  input  logic [DATA_WIDTH-1:0]   push_data,
  input  logic                    pop,
  input  logic                    flush,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic [DATA_WIDTH-1:0]   head
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [PTR_W:0]        count_r;
  logic                  do_push_s;
  logic                  do_pop_s;

  // Qualify requests against occupancy; a pop frees a slot for a same-cycle push.
  always_comb begin
    do_pop_s  = pop && (count_r != (PTR_W+1)'(0));
    do_push_s = push && ((count_r != (PTR_W+1)'(DEPTH)) || do_pop_s);
  end

  // Storage array, written on accepted push.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (PTR_W+1)'(1);
        2'b01:   count_r <= count_r - (PTR_W+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign full  = (count_r == (PTR_W+1)'(DEPTH));
  assign empty = (count_r == (PTR_W+1)'(0));
  assign count = count_r;
  assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/ref_fetch_ctrl.sv
// Port-A burst read sequencer: issues word reads, absorbs the memory's
// registered read latency and returns words as a valid/ready stream.
module ref_fetch_ctrl
  import ref_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  num_words,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int USED_W = CNT_W + 1;

  logic [1:0]            state_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [LEN_WIDTH-1:0]  len_r;
  logic [LEN_WIDTH-1:0]  issue_cnt_r;
  logic [LEN_WIDTH-1:0]  pop_cnt_r;
  logic                  pend1_r;
  logic                  pend2_r;
  logic                  busy_r;
  logic                  done_r;

  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic [CNT_W-1:0]      fifo_count_s;
  logic [DATA_WIDTH-1:0] fifo_head_s;
  logic [USED_W-1:0]     used_s;
  logic [ADDR_WIDTH-1:0] base_aligned_s;
  logic                  issue_s;
  logic                  flush_s;
  logic                  pop_s;
  logic                  push_s;
  logic                  last_head_s;

  // pend1: address on the bus this cycle; pend2: memory output valid this cycle.
  // Both hold credits so buffered plus outstanding words never exceed the FIFO.
  always_comb begin
    used_s         = USED_W'(fifo_count_s) + USED_W'(pend1_r) + USED_W'(pend2_r);
    base_aligned_s = base_addr & ~((ADDR_WIDTH'(1) << WORD_SHIFT) - ADDR_WIDTH'(1));
    flush_s        = abort && (state_r != ST_IDLE);
    pop_s          = !fifo_empty_s && m_ready && !flush_s;
    push_s         = pend2_r && !flush_s && (!fifo_full_s || pop_s);
    last_head_s    = (pop_cnt_r == (len_r - LEN_WIDTH'(1)));
    if (state_r == ST_FETCH) begin
      issue_s = !abort && (issue_cnt_r < len_r) && (used_s < USED_W'(FIFO_DEPTH));
    end else begin
      issue_s = 1'b0;
    end
  end

  // Control FSM, address/issue/return counters and the read-latency pipeline.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r     <= ST_IDLE;
      addr_r      <= '0;
      len_r       <= '0;
      issue_cnt_r <= '0;
      pop_cnt_r   <= '0;
      pend1_r     <= 1'b0;
      pend2_r     <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      done_r  <= 1'b0;
      pend1_r <= 1'b0;
      pend2_r <= pend1_r;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            if (num_words == LEN_WIDTH'(0)) begin
              done_r <= 1'b1;
            end else begin
              // The first read goes out on the accepting edge itself.
              len_r       <= num_words;
              addr_r      <= base_aligned_s;
              issue_cnt_r <= LEN_WIDTH'(1);
              pop_cnt_r   <= '0;
              pend1_r     <= 1'b1;
              busy_r      <= 1'b1;
              state_r     <= (num_words == LEN_WIDTH'(1)) ? ST_DRAIN : ST_FETCH;
            end
          end
        end
        ST_FETCH, ST_DRAIN: begin
          if (abort) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            pend1_r <= 1'b0;
            pend2_r <= 1'b0;
          end else begin
            if (issue_s) begin
              addr_r      <= addr_r + ADDR_WIDTH'(BYTES_PER_WORD);
              issue_cnt_r <= issue_cnt_r + LEN_WIDTH'(1);
              pend1_r     <= 1'b1;
              if (issue_cnt_r == (len_r - LEN_WIDTH'(1))) state_r <= ST_DRAIN;
            end
            if (pop_s) begin
              pop_cnt_r <= pop_cnt_r + LEN_WIDTH'(1);
              if (last_head_s) begin
                state_r <= ST_IDLE;
                busy_r  <= 1'b0;
                done_r  <= 1'b1;
              end
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  ref_fetch_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push_s),
    .push_data (mem_dout),
    .pop       (pop_s),
    .flush     (flush_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s),
    .head      (fifo_head_s)
  );

  assign busy     = busy_r;
  assign done     = done_r;
  assign mem_addr = addr_r;
  assign m_valid  = !fifo_empty_s;
  assign m_data   = fifo_empty_s ? DATA_WIDTH'(0) : fifo_head_s;
  assign m_last   = !fifo_empty_s && last_head_s;

endmodule

// File: doc/ref_fetch_ctrl.md
Name: ref_fetch_ctrl

Overview:
- Read sequencer for port A of the dual-port reference-sequence memory.
- Accepts a burst command (byte base address, word count) and issues sequential word reads on the memory's address port.
- Absorbs the memory's 1-cycle registered read latency and returns the words as a valid/ready stream to the aligner datapath, with full backpressure support and no lost or duplicated words.

Parameters:
- ADDR_WIDTH, 32, byte-address width; matches memory address ports.
- DATA_WIDTH, 32, word width; matches memory data ports.
- LEN_WIDTH, 16, width of burst word count.
- FIFO_DEPTH, 4, return-buffer depth in words; power of two, ≥2.

Ports:
- clk  in  1  single clock.
- resetn  in  1  reset, asynchronous, active-low.
- start  in  1  command strobe; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  burst start byte address; bits [1:0] ignored (treated as 0).
- num_words  in  LEN_WIDTH  burst length in words.
- abort  in  1  cancel current burst.
- busy  out  1  high from accepted start until done or abort.
- done  out  1  one-cycle pulse when burst completes.
- mem_addr  out  ADDR_WIDTH  drives memory addr_A.
- mem_dout  in  DATA_WIDTH  from memory dout_A; valid one cycle after mem_addr.
- m_valid  out  1  stream data valid.
- m_data  out  DATA_WIDTH  stream word.
- m_last  out  1  marks final word of burst.
- m_ready  in  1  downstream accept.

Behaviour:
- Reset (resetn=0, asynchronous): state=IDLE; busy, done, m_valid, m_last = 0; mem_addr = 0; m_data = 0; FIFO empty; counters cleared.
- States: IDLE, FETCH, DRAIN.
  - IDLE→FETCH on start with num_words≠0.
  - IDLE stays IDLE on start with num_words=0, and done pulses on the next cycle; busy stays 0.
  - FETCH→DRAIN once the last read is issued.
  - DRAIN→IDLE on the handshake of the last word.
- Issue rule: a read is issued in a cycle when issue_cnt < num_words and (fifo_count + in_flight) < FIFO_DEPTH. The issue registers mem_addr and sets in_flight for the next cycle.
- Timing from start sampled at edge E0:
  - mem_addr = base (bits [1:0] = 0) after E0.
  - Word captured into FIFO at E2.
  - m_valid = 1 after E2.
  - Sustained throughput: 1 word/cycle while m_ready=1.
- Address: increments by 4 per issue. Wraps modulo 2^ADDR_WIDTH with no error.
- When no read is issued, mem_addr holds its last value. The memory reads continuously; only tracked issues are captured.
- FIFO: first-word fall-through. m_data = FIFO head while m_valid=1. Handshake occurs when m_valid & m_ready.
  - Simultaneous push and pop at full or empty is legal.
  - The credit rule guarantees no overflow.
- m_last = 1 exactly while the head is word num_words-1. m_valid holds high and m_data stable until accepted.
- done: pulses 1 cycle after the last handshake. busy falls in the same cycle done pulses.
- start while busy: ignored. The command is latched only in IDLE.
- abort (any non-IDLE state):
  - Next cycle: IDLE, FIFO flushed, m_valid=0, busy=0.
  - No done pulse; in-flight word discarded.
  - abort has priority over a simultaneous handshake.
- num_words = 2^LEN_WIDTH-1 must be supported; counters are LEN_WIDTH wide.

Decomposition:
- Shared package ref_fetch_pkg:
  - State encoding constants IDLE/FETCH/DRAIN.
  - BYTES_PER_WORD=4, WORD_SHIFT=2.
- One sub-module: ref_fetch_fifo, a parameterised synchronous FWFT FIFO.
  - Ports: push/pop/flush/full/empty/count.
  - Same clock and asynchronous active-low reset.
- Control FSM, counters and credit logic live in the top level.

Test Plan:
- Memory word[k]=0xA000_0000+k. start, base=0x100, num_words=4, m_ready=1 → m_valid from E2, m_data=0xA0000040..0xA0000043 on 4 consecutive cycles, m_last on 4th word, done pulse the cycle after, busy low with done.
- Same burst with m_ready toggling 1,0,0,1,… → same 4 words in order, data stable while stalled, in_flight+fifo_count never exceeds 4, no duplicates.
- base=0xFFFF_FFF8, num_words=4 → words read at 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4 (wrap), m_last on word 4.
- num_words=0 → no m_valid, busy stays 0, done pulse one cycle after start.
- 16-word burst with m_ready=0 after 2 words; abort asserted → next cycle m_valid=0, busy=0, no done. A new start base=0x0, num_words=2 then returns 0xA0000000, 0xA0000001 only.
- resetn pulled low mid-burst (asynchronous, between edges) → all outputs 0 immediately. After release, start with base=0x10, num_words=1 returns 0xA0000004 with m_last=1.
